// File: rtl/mul_seq_ctrl.sv
// Operand-read sequencer for the matrix-multiply prep datapath: walks MAC steps, issues A/B reads, and drives lane-offset controls.
// Optional stall-cycle performance counter is built only when MULSEQ_PERF_CNT_EN is defined.
module mul_seq_ctrl #(
    parameter int ADDR_W = 12,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic [ADDR_W-1:0] cfg_a_base,
    input  logic [ADDR_W-1:0] cfg_b_base,
    input  logic              cfg_hash_width,
    input  logic              stall,
    output logic              busy,
    output logic              done,
    output logic              start_pos,
    output logic              short_data_mode,
    output logic              hash_width,
    output logic              short_bia_add,
    output logic              long_bia_add,
    output logic              a_ren,
    output logic [ADDR_W-1:0] a_addr,
    output logic              b_ren,
    output logic [ADDR_W-1:0] b_addr,
    output logic              mac_valid,
    output logic              mac_last,
    output logic [31:0]       perf_stall_cycles
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    state_e            state_q;
    logic [LEN_W-1:0]  len_q, k_q, k_d;
    logic [ADDR_W-1:0] a_base_q, b_base_q;
    logic [ADDR_W-1:0] a_addr_q, b_addr_q, a_addr_d, b_addr_d;
    logic              mode_q, hw_q;
    logic              busy_q, done_q, start_pos_q;
    logic              mac_valid_q, mac_last_q, short_q, long_q;
    logic              accept, issue, is_last;

    // Mode 1 broadcasts one A byte over four B lanes; mode 0 pairs four A bytes with one B lane.
    function automatic logic [ADDR_W-1:0] a_addr_of(input logic m, input logic [ADDR_W-1:0] base,
                                                    input logic [LEN_W-1:0] k);
        return m ? base + ADDR_W'(k >> 3) : base + ADDR_W'(k >> 1);
    endfunction

    function automatic logic [ADDR_W-1:0] b_addr_of(input logic m, input logic [ADDR_W-1:0] base,
                                                    input logic [LEN_W-1:0] k);
        return m ? base + ADDR_W'(k) : base + ADDR_W'(k >> 2);
    endfunction

    // Read enables follow stall in the same cycle, so they are decoded from registered state.
    assign accept  = (state_q == IDLE) && start;
    assign issue   = (state_q == RUN) && !stall && (len_q != '0);
    assign is_last = (k_q == len_q - LEN_W'(1));

    always_comb begin
        k_d      = k_q + LEN_W'(1);
        a_addr_d = a_addr_of(mode_q, a_base_q, k_d);
        b_addr_d = b_addr_of(mode_q, b_base_q, k_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            k_q         <= '0;
            a_base_q    <= '0;
            b_base_q    <= '0;
            a_addr_q    <= '0;
            b_addr_q    <= '0;
            mode_q      <= 1'b0;
            hw_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            start_pos_q <= 1'b0;
            mac_valid_q <= 1'b0;
            mac_last_q  <= 1'b0;
            short_q     <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            start_pos_q <= 1'b0;
            done_q      <= 1'b0;
            mac_valid_q <= issue;
            mac_last_q  <= issue && is_last;
            short_q     <= issue;
            long_q      <= issue && !mode_q;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q     <= RUN;
                        len_q       <= cfg_len;
                        k_q         <= '0;
                        a_base_q    <= cfg_a_base;
                        b_base_q    <= cfg_b_base;
                        a_addr_q    <= cfg_a_base;
                        b_addr_q    <= cfg_b_base;
                        mode_q      <= mode;
                        hw_q        <= cfg_hash_width;
                        busy_q      <= 1'b1;
                        start_pos_q <= 1'b1;
                    end
                end
                RUN: begin
                    // A zero-length job still spends one RUN cycle so start_pos precedes done.
                    if (len_q == '0) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else if (issue) begin
                        k_q      <= k_d;
                        a_addr_q <= a_addr_d;
                        b_addr_q <= b_addr_d;
                        if (is_last) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (mac_last_q) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign start_pos       = start_pos_q;
    assign short_data_mode = mode_q;
    assign hash_width      = hw_q;
    assign short_bia_add   = short_q;
    assign long_bia_add    = long_q;
    assign mac_valid       = mac_valid_q;
    assign mac_last        = mac_last_q;
    assign a_ren           = issue;
    assign b_ren           = issue;
    assign a_addr          = a_addr_q;
    assign b_addr          = b_addr_q;

`ifdef MULSEQ_PERF_CNT_EN
    logic [31:0] perf_q, perf_d;

    // Counts RUN cycles lost to stall; cleared per job, saturating, frozen once the job ends.
    always_comb begin
        perf_d = perf_q;
        if (accept) begin
            perf_d = '0;
        end else if ((state_q == RUN) && stall && (perf_q != '1)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_stall_cycles = perf_q;
`else
    assign perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Scoreboard bench for mul_seq_ctrl: stimulus queues expected reads, MAC strobes and pulse cycles; a negedge monitor pops and compares.
module tb_mul_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [15:0] cfg_len = '0;
    logic [11:0] cfg_a_base = '0;
    logic [11:0] cfg_b_base = '0;
    logic        cfg_hash_width = 1'b0;
    logic        stall = 1'b0;
    logic        busy, done, start_pos, short_data_mode, hash_width;
    logic        short_bia_add, long_bia_add, a_ren, b_ren, mac_valid, mac_last;
    logic [11:0] a_addr, b_addr;
    logic [31:0] perf_stall_cycles;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    logic        monEn = 1'b0;

    logic [23:0] issueQ[$];
    logic [2:0]  macQ[$];
    int          startQ[$];
    int          doneQ[$];

    mul_seq_ctrl #(.ADDR_W(12), .LEN_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .cfg_len(cfg_len),
        .cfg_a_base(cfg_a_base), .cfg_b_base(cfg_b_base), .cfg_hash_width(cfg_hash_width),
        .stall(stall), .busy(busy), .done(done), .start_pos(start_pos),
        .short_data_mode(short_data_mode), .hash_width(hash_width),
        .short_bia_add(short_bia_add), .long_bia_add(long_bia_add),
        .a_ren(a_ren), .a_addr(a_addr), .b_ren(b_ren), .b_addr(b_addr),
        .mac_valid(mac_valid), .mac_last(mac_last), .perf_stall_cycles(perf_stall_cycles)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every DUT strobe must match the head of its queue.
    always @(negedge clk) begin
        if (monEn) begin
            if (a_ren === 1'b1) begin
                checkOutput("b_ren_with_a_ren", {31'd0, b_ren}, 32'd1);
                if (issueQ.size() == 0) begin
                    checkOutput("unexpected_a_ren", {31'd0, a_ren}, 32'd0);
                end else begin
                    logic [23:0] e;
                    e = issueQ.pop_front();
                    checkOutput("a_addr", {20'd0, a_addr}, {20'd0, e[23:12]});
                    checkOutput("b_addr", {20'd0, b_addr}, {20'd0, e[11:0]});
                end
            end else begin
                checkOutput("b_ren_idle", {31'd0, b_ren}, 32'd0);
            end
            if (mac_valid === 1'b1) begin
                if (macQ.size() == 0) begin
                    checkOutput("unexpected_mac_valid", {31'd0, mac_valid}, 32'd0);
                end else begin
                    logic [2:0] m;
                    m = macQ.pop_front();
                    checkOutput("short_long_last", {29'd0, short_bia_add, long_bia_add, mac_last},
                                {29'd0, m});
                end
            end else begin
                checkOutput("bia_idle", {29'd0, short_bia_add, long_bia_add, mac_last}, 32'd0);
            end
            if (start_pos === 1'b1) begin
                if (startQ.size() == 0) checkOutput("unexpected_start_pos", {31'd0, start_pos}, 32'd0);
                else checkOutput("start_pos_cycle", cyc, startQ.pop_front());
            end
            if (done === 1'b1) begin
                if (doneQ.size() == 0) checkOutput("unexpected_done", {31'd0, done}, 32'd0);
                else checkOutput("done_cycle", cyc, doneQ.pop_front());
            end
        end
    end

    // extraStart: 0 none, >0 pulse start at that relative cycle, <0 pulse start in the done cycle.
    task automatic applyStimulus(input logic m, input logic [15:0] len, input logic [11:0] ab,
                                 input logic [11:0] bb, input logic hw, input logic [63:0] mask,
                                 input int resetAt, input int extraStart);
        int issued = 0;
        int lastIssue = 0;
        int stallRun = 0;
        int doneRel, endRel, es, t0, expPerf;
        logic [11:0] ea, eb;
        for (int c = 1; c < 64; c++) begin
            if (resetAt > 0 && c > resetAt) break;
            if (len == 0) begin
                if (c == 1 && mask[c]) stallRun++;
                break;
            end
            if (issued >= int'(len)) break;
            if (mask[c]) begin
                stallRun++;
            end else begin
                ea = m ? ab + 12'(issued / 8) : ab + 12'(issued / 2);
                eb = m ? bb + 12'(issued) : bb + 12'(issued / 4);
                issueQ.push_back({ea, eb});
                if (resetAt <= 0 || c + 1 <= resetAt)
                    macQ.push_back({1'b1, ~m, (issued == int'(len) - 1)});
                issued++;
                lastIssue = c;
            end
        end
        doneRel = (len == 0) ? 2 : lastIssue + 2;
        endRel  = (resetAt > 0) ? resetAt + 6 : doneRel + 2;
        es      = (extraStart < 0) ? doneRel : extraStart;
`ifdef MULSEQ_PERF_CNT_EN
        expPerf = stallRun;
`else
        expPerf = 0;
`endif

        @(posedge clk); #1;
        mode = m; cfg_len = len; cfg_a_base = ab; cfg_b_base = bb; cfg_hash_width = hw;
        stall = 1'b0; start = 1'b1;
        t0 = cyc;
        startQ.push_back(t0 + 1);
        if (resetAt <= 0) doneQ.push_back(t0 + doneRel);

        for (int rel = 1; rel <= endRel; rel++) begin
            @(posedge clk); #1;
            start = (es > 0 && rel == es);
            stall = (rel < 64) ? mask[rel] : 1'b0;
            rst   = (resetAt > 0 && rel == resetAt);
            if (rel == 1) begin
                checkOutput("busy_after_accept", {31'd0, busy}, 32'd1);
                checkOutput("short_data_mode", {31'd0, short_data_mode}, {31'd0, m});
                checkOutput("hash_width", {31'd0, hash_width}, {31'd0, hw});
            end
            if (rel == 2) begin
                mode = ~m; cfg_len = ~len; cfg_a_base = ~ab; cfg_b_base = ~bb;
                cfg_hash_width = ~hw;
            end
            if (resetAt <= 0 && rel == doneRel)
                checkOutput("busy_in_done", {31'd0, busy}, 32'd0);
            if (resetAt <= 0 && rel == doneRel + 1) begin
                checkOutput("perf_stall_cycles", perf_stall_cycles, expPerf);
                checkOutput("latched_mode_held", {31'd0, short_data_mode}, {31'd0, m});
            end
            if (resetAt > 0 && rel == resetAt + 1) begin
                checkOutput("reset_ctrl_zero", {21'd0, busy, done, start_pos, short_data_mode,
                            hash_width, short_bia_add, long_bia_add, a_ren, b_ren, mac_valid,
                            mac_last}, 32'd0);
                checkOutput("reset_addr_zero", {8'd0, a_addr, b_addr}, 32'd0);
                checkOutput("reset_perf_zero", perf_stall_cycles, 32'd0);
            end
        end
        start = 1'b0; stall = 1'b0; rst = 1'b0;
        checkOutput("issues_outstanding", issueQ.size(), 32'd0);
        checkOutput("macs_outstanding", macQ.size(), 32'd0);
        checkOutput("start_pos_outstanding", startQ.size(), 32'd0);
        checkOutput("done_outstanding", doneQ.size(), 32'd0);
        issueQ.delete(); macQ.delete(); startQ.delete(); doneQ.delete();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] mul_seq_ctrl scoreboard bench starting");
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("reset_state", {20'd0, busy, done, start_pos, short_data_mode, hash_width,
                    short_bia_add, long_bia_add, a_ren, b_ren, mac_valid, mac_last, 1'b0}, 32'd0);
        checkOutput("reset_addr", {8'd0, a_addr, b_addr}, 32'd0);
        checkOutput("reset_perf", perf_stall_cycles, 32'd0);
        monEn = 1'b1;

        applyStimulus(1'b1, 16'd16, 12'h010, 12'h100, 1'b1, 64'h0, 0, 3);
        applyStimulus(1'b0, 16'd8, 12'h000, 12'h000, 1'b0, 64'h0, 0, -1);
        applyStimulus(1'b1, 16'd8, 12'h000, 12'h000, 1'b1, 64'h38, 0, 0);
        applyStimulus(1'b0, 16'd0, 12'h055, 12'h0AA, 1'b1, 64'h0, 0, 0);
        applyStimulus(1'b1, 16'd8, 12'h000, 12'hFFE, 1'b0, 64'h0, 0, 0);
        applyStimulus(1'b1, 16'd16, 12'h234, 12'h456, 1'b1, 64'h0, 5, 3);
        applyStimulus(1'b0, 16'd8, 12'hFFF, 12'h123, 1'b0, 64'h2, 0, 0);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
Sequencer for the matrix-multiply operand-preparation datapath. It issues A/B memory reads and drives the lane-offset controls: short_data_mode, short_bia_add, long_bia_add, start_pos and done. A mode select determines whether A bytes are broadcast against four B lanes, or four A bytes are paired with one broadcast B lane. The block sits between the top-level FSM (start/done handshake) and the operand RAMs plus lane-select logic.

Parameters:
ADDR_W, 12, width of A and B word addresses
LEN_W, 16, width of step count cfg_len

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  request; accepted only in IDLE
mode  in  1  1 = A-byte broadcast (right multiply), 0 = B-lane broadcast (left multiply)
cfg_len  in  LEN_W  number of MAC steps; multiple of 8 or zero
cfg_a_base  in  ADDR_W  A word base address
cfg_b_base  in  ADDR_W  B word base address
cfg_hash_width  in  1  sample width select, latched at accept
stall  in  1  blocks issue of new reads
busy  out  1  operation in progress
done  out  1  one-cycle completion pulse
start_pos  out  1  one-cycle offset-clear pulse
short_data_mode  out  1  registered latched mode
hash_width  out  1  registered latched cfg_hash_width
short_bia_add  out  1  advance byte offset
long_bia_add  out  1  advance lane offset
a_ren  out  1  A read enable
a_addr  out  ADDR_W  A read address
b_ren  out  1  B read enable
b_addr  out  ADDR_W  B read address
mac_valid  out  1  RAM data valid this cycle (1-cycle read latency)
mac_last  out  1  mac_valid for final step
perf_stall_cycles  out  32  stall counter (see Optional Feature)

Behaviour:
- Reset: all outputs 0, state IDLE, step counter 0. Reset mid-operation aborts immediately and issues no done.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: when start=1, latch mode, cfg_len, both bases and cfg_hash_width, then go to RUN. If latched cfg_len==0, go to DONE instead. start while not IDLE is ignored.
- start_pos is 1 in the first cycle after accept, in both the RUN and the zero-length DONE paths.
- RUN: each cycle with stall=0 issues step k (k counts up from 0). In that cycle a_ren=b_ren=1.
  - mode 1: a_addr = a_base + k/8, b_addr = b_base + k.
  - mode 0: a_addr = a_base + k/2, b_addr = b_base + k/4.
  - Addresses are ADDR_W-bit modulo, so wrap-around is silent.
- stall=1 in RUN: a_ren=b_ren=0, k holds, addresses hold. An already-issued read still completes.
- After issuing k = cfg_len-1, go to DRAIN. In DRAIN, stall is ignored.
- mac_valid is asserted exactly 1 cycle after each issue. mac_last = mac_valid AND (issued step was cfg_len-1).
- short_bia_add = mac_valid, in both modes. long_bia_add = mac_valid AND (latched mode==0). Offsets therefore advance after each consumed word.
- DRAIN: wait for mac_last, then go to DONE next cycle.
- DONE: done=1 for one cycle, busy=0, then IDLE. A start seen in the DONE cycle is ignored.
- busy=1 from the cycle after accept through the mac_last cycle (zero-length: only the start_pos cycle), otherwise 0.
- Latency with no stall: start accepted at cycle 0.
  - start_pos and first issue at cycle 1.
  - mac_valid at cycles 2..cfg_len+1.
  - done at cycle cfg_len+2.
- short_data_mode and hash_width hold the latched values until the next accept.
- A non-multiple-of-8 cfg_len is unsupported; the block still terminates after cfg_len steps.

Optional Feature:
MULSEQ_PERF_CNT_EN:
- Defined: perf_stall_cycles counts cycles with state==RUN and stall==1. It clears on accept, saturates at 2^32-1, and holds after done.
- Undefined: perf_stall_cycles is tied to 0 and no counter logic exists.

Test Plan:
- mode=1, cfg_len=16, a_base=0x010, b_base=0x100, no stall -> a_addr 0x010 for k=0..7 and 0x011 for k=8..15; b_addr 0x100..0x10F; long_bia_add never asserts; short_bia_add pulses 16 times; done at cycle 18.
- mode=0, cfg_len=8, bases 0 -> a_addr 0,0,1,1,2,2,3,3; b_addr 0,0,0,0,1,1,1,1; long_bia_add and short_bia_add both pulse 8 times; mac_last at cycle 9.
- mode=1, cfg_len=8, stall high for cycles 3-5 -> issue pauses with addresses held; 8 mac_valid total; done at cycle 13; perf_stall_cycles=3 with macro, 0 without.
- cfg_len=0 -> start_pos at cycle 1, done at cycle 2, no a_ren/b_ren/mac_valid.
- b_base=0xFFE, mode=1, cfg_len=8 -> b_addr 0xFFE, 0xFFF, 0x000 ... 0x005 (wrap).
- rst asserted at cycle 5 of a 16-step run; start pulsed during busy -> all outputs 0 and IDLE next cycle, no done; the start during busy is ignored.
